// File: rtl/bram_arb_pkg.sv
// Shared definitions for the BRAM arbiter: request-op encoding and the
// requester-index width helper.
package bram_arb_pkg;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    // Index width for n requesters, never narrower than one bit.
    function automatic int idw_calc(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bram_sdp.sv
// Simple dual-port block RAM: one write port, one registered read port.
// Reads of an address written on the same edge return the old contents.
module bram_sdp #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256,
    parameter int ADDRW = $clog2(DEPTH)
) (
    input  logic             clk_write,
    input  logic             we,
    input  logic [ADDRW-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             clk_read,
    input  logic             re,
    input  logic [ADDRW-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Write port; storage has no reset so contents survive it.
    always_ff @(posedge clk_write) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read port.
    always_ff @(posedge clk_read) begin
        if (re) begin
            rdata <= mem_r[raddr];
        end
    end

endmodule

// File: rtl/bram_arbiter.sv
// Round-robin arbiter sharing one simple dual-port BRAM between NREQ requesters.
// Define BRAM_ARB_FWD_EN to forward write data to a same-cycle same-address read.
module bram_arbiter
    import bram_arb_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 256,
    parameter  int NREQ  = 2,
    localparam int ADDRW = $clog2(DEPTH),
    localparam int IDW   = idw_calc(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ-1:0]         req_we,
    input  logic [NREQ*ADDRW-1:0]   req_addr,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic                    rsp_valid,
    output logic [IDW-1:0]          rsp_id,
    output logic [WIDTH-1:0]        rsp_data
);

    logic [NREQ-1:0]  wr_elig_s, rd_elig_s;
    logic [ADDRW-1:0] addr_a_s [NREQ];
    logic [WIDTH-1:0] data_a_s [NREQ];
    logic [IDW:0]     wr_pick_s, rd_pick_s;
    logic [IDW-1:0]   wr_idx_s, rd_idx_s;
    logic             wr_go_s, rd_go_s;
    logic [NREQ-1:0]  wr_gnt_s, rd_gnt_s;
    logic [ADDRW-1:0] wr_addr_s, rd_addr_s;
    logic [WIDTH-1:0] wr_data_s;
    logic [WIDTH-1:0] bram_rdata_s, mem_out_s;
    logic [IDW-1:0]   wr_ptr_r, rd_ptr_r;
    logic             rsp_valid_r;
    logic [IDW-1:0]   rsp_id_r;

    // First set bit of elig at or after ptr, wrapping; MSB of result flags a hit.
    function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] elig,
                                              input logic [IDW-1:0]  ptr);
        logic [IDW:0] res;
        int           idx;
        res = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!res[IDW] && elig[idx[IDW-1:0]]) begin
                res = {1'b1, idx[IDW-1:0]};
            end
        end
        return res;
    endfunction

    function automatic logic [IDW-1:0] ptr_next(input logic [IDW-1:0] g);
        int n;
        n = ((int'(g) + 1) >= NREQ) ? 0 : (int'(g) + 1);
        return n[IDW-1:0];
    endfunction

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign wr_elig_s[i] = req_valid[i] && (req_we[i] == OP_WRITE);
        assign rd_elig_s[i] = req_valid[i] && (req_we[i] == OP_READ);
        assign addr_a_s[i]  = req_addr[i*ADDRW +: ADDRW];
        assign data_a_s[i]  = req_data[i*WIDTH +: WIDTH];
    end

    // Independent write and read arbitration; nothing is granted during reset.
    always_comb begin
        wr_pick_s = rr_pick(wr_elig_s, wr_ptr_r);
        rd_pick_s = rr_pick(rd_elig_s, rd_ptr_r);
        wr_idx_s  = wr_pick_s[IDW-1:0];
        rd_idx_s  = rd_pick_s[IDW-1:0];
        wr_go_s   = wr_pick_s[IDW] && !rst;
        rd_go_s   = rd_pick_s[IDW] && !rst;
        wr_gnt_s  = '0;
        rd_gnt_s  = '0;
        if (wr_go_s) begin
            wr_gnt_s[wr_idx_s] = 1'b1;
        end else begin
            wr_gnt_s = '0;
        end
        if (rd_go_s) begin
            rd_gnt_s[rd_idx_s] = 1'b1;
        end else begin
            rd_gnt_s = '0;
        end
        wr_addr_s = addr_a_s[wr_idx_s];
        wr_data_s = data_a_s[wr_idx_s];
        rd_addr_s = addr_a_s[rd_idx_s];
        req_ready = wr_gnt_s | rd_gnt_s;
    end

    // Round-robin pointers and response tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= '0;
        end else begin
            rsp_valid_r <= rd_go_s;
            if (wr_go_s) begin
                wr_ptr_r <= ptr_next(wr_idx_s);
            end
            if (rd_go_s) begin
                rd_ptr_r <= ptr_next(rd_idx_s);
                rsp_id_r <= rd_idx_s;
            end
        end
    end

    bram_sdp #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .ADDRW (ADDRW)
    ) u_bram (
        .clk_write (clk),
        .we        (wr_go_s),
        .waddr     (wr_addr_s),
        .wdata     (wr_data_s),
        .clk_read  (clk),
        .re        (rd_go_s),
        .raddr     (rd_addr_s),
        .rdata     (bram_rdata_s)
    );

`ifdef BRAM_ARB_FWD_EN
    logic             fwd_hit_r;
    logic [WIDTH-1:0] fwd_data_r;

    // Capture write data when a read collides with a write to the same address.
    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_hit_r  <= 1'b0;
            fwd_data_r <= '0;
        end else begin
            fwd_hit_r  <= rd_go_s && wr_go_s && (rd_addr_s == wr_addr_s);
            fwd_data_r <= wr_data_s;
        end
    end

    assign mem_out_s = fwd_hit_r ? fwd_data_r : bram_rdata_s;
`else
    assign mem_out_s = bram_rdata_s;
`endif

    // A response whose cycle coincides with reset is dropped; data is zero when idle.
    always_comb begin
        rsp_valid = rsp_valid_r && !rst;
        if (rst) begin
            rsp_id = '0;
        end else begin
            rsp_id = rsp_id_r;
        end
        if (rsp_valid) begin
            rsp_data = mem_out_s;
        end else begin
            rsp_data = '0;
        end
    end

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed self-checking bench for bram_arbiter (WIDTH=8, DEPTH=256, NREQ=2).
module tb_bram_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_we;
    logic [15:0] req_addr;
    logic [15:0] req_data;
    logic [1:0]  req_ready;
    logic        rsp_valid;
    logic [0:0]  rsp_id;
    logic [7:0]  rsp_data;

    int tests = 0;
    int fails = 0;

    logic [1:0] exp_rdy;
    logic [0:0] exp_id;
    logic [7:0] exp_d;
    logic [7:0] rd_a;
    logic [7:0] coll_exp;

    bram_arbiter #(
        .WIDTH (8),
        .DEPTH (256),
        .NREQ  (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] we,
                         input logic [7:0] a1, input logic [7:0] a0,
                         input logic [7:0] d1, input logic [7:0] d0);
        req_valid = v;
        req_we    = we;
        req_addr  = {a1, a0};
        req_data  = {d1, d0};
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 2'b00;
        req_we    = 2'b00;
        req_addr  = 16'h0000;
        req_data  = 16'h0000;

        // Reset held two cycles with both requesters reading
        drive(2'b11, 2'b00, 8'd1, 8'd2, 8'h00, 8'h00);
        tick();
        tick();
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_id", 32'(rsp_id), 32'h0);
        check("rst_rsp_data", 32'(rsp_data), 32'h0);

        // Write 0xA5 to addr 5 from req0, then read it back from req1
        rst = 1'b0;
        drive(2'b01, 2'b01, 8'd0, 8'd5, 8'h00, 8'hA5);
        check("wr_ready", 32'(req_ready), 32'h1);
        tick();
        drive(2'b10, 2'b00, 8'd5, 8'd0, 8'h00, 8'h00);
        check("rd_ready", 32'(req_ready), 32'h2);
        check("wr_no_rsp", 32'(rsp_valid), 32'h0);
        tick();
        drive(2'b00, 2'b00, 8'd0, 8'd0, 8'h00, 8'h00);
        check("wtr_valid", 32'(rsp_valid), 32'h1);
        check("wtr_id", 32'(rsp_id), 32'h1);
        check("wtr_data", 32'(rsp_data), 32'hA5);

        // Fairness: both read every cycle, grants alternate starting at 0
        for (int i = 0; i < 6; i++) begin
            drive(2'b11, 2'b00, 8'd5, 8'd5, 8'h00, 8'h00);
            exp_rdy = (i % 2 == 0) ? 2'b01 : 2'b10;
            exp_id  = (i % 2 == 0) ? 1'b1 : 1'b0;
            check("fair_ready", 32'(req_ready), 32'(exp_rdy));
            if (i > 0) begin
                check("fair_valid", 32'(rsp_valid), 32'h1);
                check("fair_id", 32'(rsp_id), 32'(exp_id));
            end
            tick();
        end
        drive(2'b00, 2'b00, 8'd0, 8'd0, 8'h00, 8'h00);
        check("fair_last_valid", 32'(rsp_valid), 32'h1);
        check("fair_last_id", 32'(rsp_id), 32'h1);

        // Collision: addr 9 holds 0x11, then same-cycle write 0x3C and read
        drive(2'b01, 2'b01, 8'd0, 8'd9, 8'h00, 8'h11);
        check("pre_ready", 32'(req_ready), 32'h1);
        tick();
        drive(2'b11, 2'b01, 8'd9, 8'd9, 8'h00, 8'h3C);
        check("coll_ready", 32'(req_ready), 32'h3);
        tick();
`ifdef BRAM_ARB_FWD_EN
        coll_exp = 8'h3C;
`else
        coll_exp = 8'h11;
`endif
        drive(2'b00, 2'b00, 8'd0, 8'd0, 8'h00, 8'h00);
        check("coll_valid", 32'(rsp_valid), 32'h1);
        check("coll_id", 32'(rsp_id), 32'h1);
        check("coll_data", 32'(rsp_data), 32'(coll_exp));
        drive(2'b10, 2'b00, 8'd9, 8'd0, 8'h00, 8'h00);
        check("post_ready", 32'(req_ready), 32'h2);
        tick();
        drive(2'b00, 2'b00, 8'd0, 8'd0, 8'h00, 8'h00);
        check("post_data", 32'(rsp_data), 32'h3C);

        // Reset right after a read grant drops the response and clears pointers
        drive(2'b01, 2'b00, 8'd0, 8'd9, 8'h00, 8'h00);
        check("midrst_grant", 32'(req_ready), 32'h1);
        tick();
        rst = 1'b1;
        drive(2'b10, 2'b00, 8'd9, 8'd0, 8'h00, 8'h00);
        check("midrst_ready", 32'(req_ready), 32'h0);
        check("midrst_valid", 32'(rsp_valid), 32'h0);
        check("midrst_data", 32'(rsp_data), 32'h0);
        tick();
        rst = 1'b0;
        drive(2'b11, 2'b00, 8'd5, 8'd5, 8'h00, 8'h00);
        check("midrst_ptr", 32'(req_ready), 32'h1);
        check("midrst_valid2", 32'(rsp_valid), 32'h0);
        tick();
        drive(2'b00, 2'b00, 8'd0, 8'd0, 8'h00, 8'h00);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'h1);
        check("midrst_rsp_id", 32'(rsp_id), 32'h0);
        check("midrst_rsp_data", 32'(rsp_data), 32'hA5);

        // Lone requester 1: four back-to-back reads alternating addr 5 / 9
        for (int i = 0; i < 4; i++) begin
            rd_a  = (i % 2 == 0) ? 8'd5 : 8'd9;
            exp_d = (i % 2 == 0) ? 8'h3C : 8'hA5;
            drive(2'b10, 2'b00, rd_a, 8'd0, 8'h00, 8'h00);
            check("lone_ready", 32'(req_ready), 32'h2);
            if (i > 0) begin
                check("lone_valid", 32'(rsp_valid), 32'h1);
                check("lone_id", 32'(rsp_id), 32'h1);
                check("lone_data", 32'(rsp_data), 32'(exp_d));
            end
            tick();
        end
        drive(2'b00, 2'b00, 8'd0, 8'd0, 8'h00, 8'h00);
        check("lone_last_valid", 32'(rsp_valid), 32'h1);
        check("lone_last_data", 32'(rsp_data), 32'h3C);
        tick();
        check("idle_valid", 32'(rsp_valid), 32'h0);
        check("idle_data", 32'(rsp_data), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bram_arbiter.md
BRAM_ARBITER -- requirements
Module: bram_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 256, words of storage.
REQ-003 SHALL have parameter NREQ, default 2, number of requesters (2..8).
REQ-004 SHALL have derived parameters ADDRW = $clog2(DEPTH) and IDW = max(1, $clog2(NREQ)).
REQ-005 SHALL have port clk, input, 1 bit: single clock for all logic and both memory ports.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port req_valid, input, NREQ bits: per-requester request valid.
REQ-008 SHALL have port req_we, input, NREQ bits: per-requester op (1 = write, 0 = read).
REQ-009 SHALL have port req_addr, input, NREQ*ADDRW bits: packed addresses, requester i at [i*ADDRW +: ADDRW].
REQ-010 SHALL have port req_data, input, NREQ*WIDTH bits: packed write data, same packing.
REQ-011 SHALL have port req_ready, output, NREQ bits: grant; the request is accepted in any cycle where valid and ready are both high.
REQ-012 SHALL have port rsp_valid, output, 1 bit: read data valid.
REQ-013 SHALL have port rsp_id, output, IDW bits: index of the requester owning the response.
REQ-014 SHALL have port rsp_data, output, WIDTH bits: read data.

Function
REQ-015 SHALL contain one simple dual-port memory; a write grant and a read grant SHALL both be issued in the same cycle when requested.
REQ-016 SHALL arbitrate writes (valid & we) and reads (valid & !we) independently, each with its own round-robin pointer.
REQ-017 SHALL grant the first eligible requester at or after the pointer, searching upward modulo NREQ.
REQ-018 SHALL, after a grant to index g, load the pointer with (g+1) mod NREQ; with no grant the pointer SHALL hold.
REQ-019 SHALL drive req_ready combinationally in the same cycle as the grant; ready SHALL never be high while valid is low.
REQ-020 SHALL commit a granted write to memory at the clock edge ending the grant cycle.
REQ-021 SHALL assert rsp_valid exactly one cycle after a read grant, with rsp_id equal to the granted index; the latency is fixed at 1.
REQ-022 SHALL force rsp_data to zero whenever rsp_valid is low.
REQ-023 SHALL return the new data for a read granted in the cycle after a write to the same address.
REQ-024 SHALL sustain one read and one write per cycle with no bubbles; a lone requester SHALL be granted every cycle.
REQ-025 SHALL NOT backpressure responses; the consumer always accepts rsp_valid.

Reset
REQ-026 SHALL, with rst high at a clock edge, set both pointers to 0, rsp_valid to 0, rsp_id to 0 and rsp_data to 0.
REQ-027 SHALL drive all req_ready bits low during any cycle in which rst is high.
REQ-028 SHALL drop a response pending from a read granted in the cycle before reset.
REQ-029 SHALL retain memory contents across reset.

Configuration
REQ-030 SHALL, with macro BRAM_ARB_FWD_EN defined, return the write data on the response for a read and write granted the same cycle to the same address.
REQ-031 SHALL, without BRAM_ARB_FWD_EN, return the pre-write memory contents in that case.

Structure
REQ-032 SHALL place the IDW computation helper and the request-op encoding constants in shared package bram_arb_pkg.
REQ-033 SHALL instantiate the team's simple dual-port BRAM, bram_sdp, as the single sub-module, with clk driving both its ports.

Verification (WIDTH=8, DEPTH=256, NREQ=2)
REQ-034 SHALL cover reset: rst high for 2 cycles with requests active -> req_ready=00, rsp_valid=0, rsp_id=0, rsp_data=0x00.
REQ-035 SHALL cover write-then-read: req0 writes 0xA5 to addr 5, next cycle req1 reads addr 5 -> one cycle later rsp_valid=1, rsp_id=1, rsp_data=0xA5.
REQ-036 SHALL cover fairness: both requesters read continuously for 6 cycles -> grants alternate 0,1,0,1,0,1 and rsp_id follows one cycle later.
REQ-037 SHALL cover same-cycle collision: addr 9 holds 0x11; req0 writes 0x3C to addr 9 while req1 reads addr 9 -> rsp_data=0x3C with BRAM_ARB_FWD_EN, 0x11 without, and a later read returns 0x3C.
REQ-038 SHALL cover reset mid-operation: read granted in cycle N, rst high in cycle N+1 -> rsp_valid stays 0 and the next grant goes to requester 0.
REQ-039 SHALL cover a lone requester: req1 issues 4 back-to-back reads -> req_ready[1]=1 every cycle and 4 consecutive responses.
